// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, counts retired instructions and halts on system, illegal or bus-timeout events.
module mc_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [31:0] instret,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    st_fetch  = 3'd0,
    st_decode = 3'd1,
    st_exec   = 3'd2,
    st_mem    = 3'd3,
    st_wb     = 3'd4,
    st_halt   = 3'd5
  } state_t;

  localparam logic [6:0] op_op     = 7'b0110011;
  localparam logic [6:0] op_imm    = 7'b0010011;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_jal    = 7'b1101111;
  localparam logic [6:0] op_jalr   = 7'b1100111;
  localparam logic [6:0] op_lui    = 7'b0110111;
  localparam logic [6:0] op_auipc  = 7'b0010111;
  localparam logic [6:0] op_fence  = 7'b0001111;
  localparam logic [6:0] op_system = 7'b1110011;

  localparam bit              wait_en  = (MAX_WAIT != 0);
  localparam logic [WAIT_W-1:0] wait_lim = WAIT_W'(MAX_WAIT - 1);

  function automatic logic is_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      op_op, op_imm, op_load, op_store, op_branch, op_jal,
      op_jalr, op_lui, op_auipc, op_fence, op_system: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               illegal_r;
  logic               bus_err_r;
  logic [31:0]        instret_r;
  logic               set_illegal_s;
  logic               set_bus_err_s;
  logic               wait_hit_s;
  logic [6:0]         opcode_s;
  logic               unused_s;

  assign opcode_s = instr[6:0];
  assign unused_s = ^instr[31:7];

  // Timeout fires on the cycle the stalled request would complete its MAX_WAIT-th wait.
  assign wait_hit_s = wait_en && (wait_cnt_r == wait_lim) && !mem_ready;

  assign instret = rst ? 32'd0 : instret_r;
  assign halted  = !rst && (state_r == st_halt);
  assign illegal = !rst && illegal_r;
  assign bus_err = !rst && bus_err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= st_fetch;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control decode; everything stays 0 while rst is high.
  always_comb begin
    state_nxt_s   = state_r;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 2'd0;
    alu_a_sel     = 2'd0;
    alu_b_sel     = 1'b0;
    alu_op        = 2'd0;
    reg_we        = 1'b0;
    wb_sel        = 2'd0;
    set_illegal_s = 1'b0;
    set_bus_err_s = 1'b0;
    if (rst) begin
      state_nxt_s = st_fetch;
    end else begin
      case (state_r)
        st_fetch: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we       = 1'b1;
            state_nxt_s = st_decode;
          end else if (wait_hit_s) begin
            set_bus_err_s = 1'b1;
            state_nxt_s   = st_halt;
          end else begin
            state_nxt_s = st_fetch;
          end
        end
        st_decode: begin
          if (!is_legal(opcode_s)) begin
            set_illegal_s = 1'b1;
            state_nxt_s   = st_halt;
          end else if (opcode_s == op_system) begin
            state_nxt_s = st_halt;
          end else begin
            state_nxt_s = st_exec;
          end
        end
        st_exec: begin
          case (opcode_s)
            op_op: begin
              alu_op      = 2'd1;
              state_nxt_s = st_wb;
            end
            op_imm: begin
              alu_b_sel   = 1'b1;
              alu_op      = 2'd1;
              state_nxt_s = st_wb;
            end
            op_lui: begin
              alu_a_sel   = 2'd2;
              alu_b_sel   = 1'b1;
              state_nxt_s = st_wb;
            end
            op_auipc: begin
              alu_a_sel   = 2'd1;
              alu_b_sel   = 1'b1;
              state_nxt_s = st_wb;
            end
            op_load, op_store: begin
              alu_b_sel   = 1'b1;
              state_nxt_s = st_mem;
            end
            op_branch: begin
              alu_a_sel   = 2'd1;
              alu_b_sel   = 1'b1;
              pc_we       = 1'b1;
              pc_src      = br_taken ? 2'd1 : 2'd0;
              state_nxt_s = st_fetch;
            end
            op_jal: begin
              alu_a_sel   = 2'd1;
              alu_b_sel   = 1'b1;
              reg_we      = 1'b1;
              wb_sel      = 2'd2;
              pc_we       = 1'b1;
              pc_src      = 2'd1;
              state_nxt_s = st_fetch;
            end
            op_jalr: begin
              alu_b_sel   = 1'b1;
              reg_we      = 1'b1;
              wb_sel      = 2'd2;
              pc_we       = 1'b1;
              pc_src      = 2'd2;
              state_nxt_s = st_fetch;
            end
            op_fence: begin
              pc_we       = 1'b1;
              state_nxt_s = st_fetch;
            end
            default: begin
              set_illegal_s = 1'b1;
              state_nxt_s   = st_halt;
            end
          endcase
        end
        st_mem: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode_s == op_store) ? 1'b1 : 1'b0;
          if (mem_ready) begin
            if (opcode_s == op_store) begin
              pc_we       = 1'b1;
              state_nxt_s = st_fetch;
            end else begin
              state_nxt_s = st_wb;
            end
          end else if (wait_hit_s) begin
            set_bus_err_s = 1'b1;
            state_nxt_s   = st_halt;
          end else begin
            state_nxt_s = st_mem;
          end
        end
        st_wb: begin
          reg_we      = 1'b1;
          wb_sel      = (opcode_s == op_load) ? 2'd1 : 2'd0;
          pc_we       = 1'b1;
          state_nxt_s = st_fetch;
        end
        st_halt: begin
          state_nxt_s = st_halt;
        end
        default: begin
          state_nxt_s = st_halt;
        end
      endcase
    end
  end

  // Wait counter: counts stalled request cycles, cleared by any non-stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (mem_req && !mem_ready && !wait_hit_s) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Sticky halt causes and the retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
      instret_r <= 32'd0;
    end else begin
      illegal_r <= illegal_r | set_illegal_s;
      bus_err_r <= bus_err_r | set_bus_err_s;
      instret_r <= instret_r + {31'd0, pc_we};
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control words are queued by the
// stimulus process and compared by an independent negedge monitor.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_sel, reg_we;
  logic [1:0]  pc_src, alu_a_sel, alu_op, wb_sel;
  logic [31:0] instret;
  logic        halted, illegal, bus_err;

  mc_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .instret(instret),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] i_addi  = 32'h00500093;
  localparam logic [31:0] i_lw    = 32'h0000A103;
  localparam logic [31:0] i_sw    = 32'h00112223;
  localparam logic [31:0] i_beq   = 32'h00000463;
  localparam logic [31:0] i_jalr  = 32'h008100E7;
  localparam logic [31:0] i_jal   = 32'h010000EF;
  localparam logic [31:0] i_lui   = 32'h12345037;
  localparam logic [31:0] i_auipc = 32'h00001017;
  localparam logic [31:0] i_add   = 32'h002081B3;
  localparam logic [31:0] i_fence = 32'h0000000F;
  localparam logic [31:0] i_bad   = 32'h0000007F;
  localparam logic [31:0] i_bad2  = 32'h00000012;
  localparam logic [31:0] i_ecall = 32'h00000073;

  typedef struct {
    logic [17:0] ctl;
    logic [31:0] ret;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  logic [17:0] act_ctl;
  assign act_ctl = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_a_sel,
                    alu_b_sel, alu_op, reg_we, wb_sel, halted, illegal, bus_err};

  // mem = {req, we, addr_sel}; flg = {halted, illegal, bus_err}
  function automatic logic [17:0] mk(input logic [2:0] mem, input logic irwe, pcwe,
                                     input logic [1:0] pcs, aa, input logic bb,
                                     input logic [1:0] op, input logic rwe,
                                     input logic [1:0] wb, input logic [2:0] flg);
    return {mem, irwe, pcwe, pcs, aa, bb, op, rwe, wb, flg};
  endfunction

  // Monitor: compares every cycle that has an expectation queued.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act_ctl !== e.ctl || instret !== e.ret) begin
        failures++;
        $display("FAIL %s: got ctl=%05h instret=%0d, want ctl=%05h instret=%0d",
                 e.name, act_ctl, instret, e.ctl, e.ret);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic [31:0] ins, input logic rdy,
                     input logic br, input logic [17:0] ctl, input logic [31:0] ret);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    instr = ins;
    mem_ready = rdy;
    br_taken = br;
    e.ctl = ctl;
    e.ret = ret;
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    logic [17:0] z, f_ok, f_w, wb_alu, wb_ld, ex_opimm, ex_ldst, mem_ld, mem_st;
    logic [17:0] ex_bt, ex_bn, ex_jalr, ex_jal, ex_lui, ex_auipc, ex_r, ex_fence;
    logic [17:0] h_ill, h_ok, h_bus;
    z        = 18'd0;
    f_ok     = mk(3'b100, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000);
    f_w      = mk(3'b100, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000);
    wb_alu   = mk(3'b000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 3'b000);
    wb_ld    = mk(3'b000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 3'b000);
    ex_opimm = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 3'b000);
    ex_ldst  = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000);
    mem_ld   = mk(3'b101, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000);
    mem_st   = mk(3'b111, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000);
    ex_bt    = mk(3'b000, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000);
    ex_bn    = mk(3'b000, 1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000);
    ex_jalr  = mk(3'b000, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 2'd0, 1'b1, 2'd2, 3'b000);
    ex_jal   = mk(3'b000, 1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 2'd0, 1'b1, 2'd2, 3'b000);
    ex_lui   = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000);
    ex_auipc = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000);
    ex_r     = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, 1'b0, 2'd0, 3'b000);
    ex_fence = mk(3'b000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000);
    h_ill    = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b110);
    h_ok     = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b100);
    h_bus    = mk(3'b000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 3'b101);

    cyc("rst_a",      1'b1, 32'd0,   1'b0, 1'b0, z, 32'd0);
    cyc("rst_b",      1'b1, 32'd0,   1'b1, 1'b0, z, 32'd0);
    // ADDI, zero-wait
    cyc("addi_fetch", 1'b0, i_addi,  1'b1, 1'b0, f_ok,     32'd0);
    cyc("addi_dec",   1'b0, i_addi,  1'b0, 1'b0, z,        32'd0);
    cyc("addi_exec",  1'b0, i_addi,  1'b0, 1'b0, ex_opimm, 32'd0);
    cyc("addi_wb",    1'b0, i_addi,  1'b0, 1'b0, wb_alu,   32'd0);
    // LW with three wait cycles in MEM
    cyc("lw_fetch",   1'b0, i_lw,    1'b1, 1'b0, f_ok,     32'd1);
    cyc("lw_dec",     1'b0, i_lw,    1'b0, 1'b0, z,        32'd1);
    cyc("lw_exec",    1'b0, i_lw,    1'b0, 1'b0, ex_ldst,  32'd1);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, i_lw, 1'b0, 1'b0, mem_ld, 32'd1);
    cyc("lw_mem_rdy", 1'b0, i_lw,    1'b1, 1'b0, mem_ld,   32'd1);
    cyc("lw_wb",      1'b0, i_lw,    1'b0, 1'b0, wb_ld,    32'd1);
    // SW, zero-wait
    cyc("sw_fetch",   1'b0, i_sw,    1'b1, 1'b0, f_ok,     32'd2);
    cyc("sw_dec",     1'b0, i_sw,    1'b0, 1'b0, z,        32'd2);
    cyc("sw_exec",    1'b0, i_sw,    1'b0, 1'b0, ex_ldst,  32'd2);
    cyc("sw_mem",     1'b0, i_sw,    1'b1, 1'b0, mem_st,   32'd2);
    // BEQ taken then not taken
    cyc("beqt_fetch", 1'b0, i_beq,   1'b1, 1'b0, f_ok,     32'd3);
    cyc("beqt_dec",   1'b0, i_beq,   1'b0, 1'b0, z,        32'd3);
    cyc("beqt_exec",  1'b0, i_beq,   1'b0, 1'b1, ex_bt,    32'd3);
    cyc("beqn_fetch", 1'b0, i_beq,   1'b1, 1'b1, f_ok,     32'd4);
    cyc("beqn_dec",   1'b0, i_beq,   1'b0, 1'b1, z,        32'd4);
    cyc("beqn_exec",  1'b0, i_beq,   1'b0, 1'b0, ex_bn,    32'd4);
    // JALR / JAL
    cyc("jalr_fetch", 1'b0, i_jalr,  1'b1, 1'b0, f_ok,     32'd5);
    cyc("jalr_dec",   1'b0, i_jalr,  1'b0, 1'b0, z,        32'd5);
    cyc("jalr_exec",  1'b0, i_jalr,  1'b0, 1'b0, ex_jalr,  32'd5);
    cyc("jal_fetch",  1'b0, i_jal,   1'b1, 1'b0, f_ok,     32'd6);
    cyc("jal_dec",    1'b0, i_jal,   1'b0, 1'b0, z,        32'd6);
    cyc("jal_exec",   1'b0, i_jal,   1'b0, 1'b0, ex_jal,   32'd6);
    // LUI / AUIPC / R-type
    cyc("lui_fetch",  1'b0, i_lui,   1'b1, 1'b0, f_ok,     32'd7);
    cyc("lui_dec",    1'b0, i_lui,   1'b0, 1'b0, z,        32'd7);
    cyc("lui_exec",   1'b0, i_lui,   1'b0, 1'b0, ex_lui,   32'd7);
    cyc("lui_wb",     1'b0, i_lui,   1'b0, 1'b0, wb_alu,   32'd7);
    cyc("aui_fetch",  1'b0, i_auipc, 1'b1, 1'b0, f_ok,     32'd8);
    cyc("aui_dec",    1'b0, i_auipc, 1'b0, 1'b0, z,        32'd8);
    cyc("aui_exec",   1'b0, i_auipc, 1'b0, 1'b0, ex_auipc, 32'd8);
    cyc("aui_wb",     1'b0, i_auipc, 1'b0, 1'b0, wb_alu,   32'd8);
    cyc("add_fetch",  1'b0, i_add,   1'b1, 1'b0, f_ok,     32'd9);
    cyc("add_dec",    1'b0, i_add,   1'b0, 1'b0, z,        32'd9);
    cyc("add_exec",   1'b0, i_add,   1'b0, 1'b0, ex_r,     32'd9);
    cyc("add_wb",     1'b0, i_add,   1'b0, 1'b0, wb_alu,   32'd9);
    // FENCE: ready arrives exactly at the wait limit and must win
    for (int i = 0; i < 3; i++) cyc("fence_fwait", 1'b0, i_fence, 1'b0, 1'b0, f_w, 32'd10);
    cyc("fence_flim", 1'b0, i_fence, 1'b1, 1'b0, f_ok,     32'd10);
    cyc("fence_dec",  1'b0, i_fence, 1'b0, 1'b0, z,        32'd10);
    cyc("fence_exec", 1'b0, i_fence, 1'b0, 1'b0, ex_fence, 32'd10);
    // Illegal opcode halts; mem_ready while halted is ignored
    cyc("ill_fetch",  1'b0, i_bad,   1'b1, 1'b0, f_ok,     32'd11);
    cyc("ill_dec",    1'b0, i_bad,   1'b0, 1'b0, z,        32'd11);
    cyc("ill_halt",   1'b0, i_bad,   1'b0, 1'b0, h_ill,    32'd11);
    cyc("ill_hold",   1'b0, i_bad,   1'b1, 1'b0, h_ill,    32'd11);
    // ECALL after fresh reset
    cyc("rst_ecall",  1'b1, i_ecall, 1'b0, 1'b0, z,        32'd0);
    cyc("ecall_fetch",1'b0, i_ecall, 1'b1, 1'b0, f_ok,     32'd0);
    cyc("ecall_dec",  1'b0, i_ecall, 1'b0, 1'b0, z,        32'd0);
    cyc("ecall_halt", 1'b0, i_ecall, 1'b0, 1'b0, h_ok,     32'd0);
    cyc("ecall_hold", 1'b0, i_ecall, 1'b1, 1'b0, h_ok,     32'd0);
    // Compressed-looking encoding (low bits != 11) is illegal
    cyc("rst_bad2",   1'b1, i_bad2,  1'b0, 1'b0, z,        32'd0);
    cyc("bad2_fetch", 1'b0, i_bad2,  1'b1, 1'b0, f_ok,     32'd0);
    cyc("bad2_dec",   1'b0, i_bad2,  1'b0, 1'b0, z,        32'd0);
    cyc("bad2_halt",  1'b0, i_bad2,  1'b0, 1'b0, h_ill,    32'd0);
    // Fetch timeout with MAX_WAIT=4
    cyc("rst_bus",    1'b1, i_addi,  1'b0, 1'b0, z,        32'd0);
    for (int i = 0; i < 4; i++) cyc("bus_fwait", 1'b0, i_addi, 1'b0, 1'b0, f_w, 32'd0);
    cyc("bus_halt",   1'b0, i_addi,  1'b0, 1'b0, h_bus,    32'd0);
    cyc("bus_hold",   1'b0, i_addi,  1'b1, 1'b0, h_bus,    32'd0);
    // Reset in the middle of a fetch wait restarts the wait count
    cyc("rst_bus2",   1'b1, i_addi,  1'b0, 1'b0, z,        32'd0);
    cyc("mid_fwait",  1'b0, i_addi,  1'b0, 1'b0, f_w,      32'd0);
    cyc("mid_fwait",  1'b0, i_addi,  1'b0, 1'b0, f_w,      32'd0);
    cyc("mid_rst",    1'b1, i_addi,  1'b0, 1'b0, z,        32'd0);
    for (int i = 0; i < 4; i++) cyc("post_fwait", 1'b0, i_addi, 1'b0, 1'b0, f_w, 32'd0);
    cyc("post_halt",  1'b0, i_addi,  1'b0, 1'b0, h_bus,    32'd0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle RV32I control FSM. Sequences the shared datapath: PC/IR registers, register file, immediate generator, one ALU, and one unified memory port.
- Reads the latched instruction from IR. Drives mux selects, write enables and a req/ready memory handshake.
- Counts retired instructions. Halts on ECALL/EBREAK, illegal opcode or memory timeout.

Parameters:
- MAX_WAIT, 255, maximum cycles mem_req may stay high without mem_ready before bus error; 0 disables the timeout.
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory accepts or completes the current request this cycle.
- br_taken  in  1  branch comparator result for IR funct3/rs1/rs2; sampled in EXEC.
- mem_req  out  1  memory request.
- mem_we  out  1  store when 1.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = ALU result, 2 = ALU result with bit0 cleared.
- alu_a_sel  out  2  0 = rs1, 1 = PC, 2 = zero.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- alu_op  out  2  0 = ADD, 1 = funct-decoded (R/OP-IMM), 2 = SUB.
- reg_we  out  1  register file write.
- wb_sel  out  2  0 = ALU result, 1 = memory read data, 2 = PC+4.
- instret  out  32  retired-instruction count; wraps.
- halted  out  1  sticky; FSM in HALT.
- illegal  out  1  sticky; halt cause is an illegal opcode.
- bus_err  out  1  sticky; halt cause is a memory timeout.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Encoding is free. Outputs are combinational from state, instr[6:0], mem_ready and br_taken. Any output not listed for a state is 0.
- Reset: next state is FETCH. instret, halted, illegal, bus_err and the wait counter are all 0. In the reset cycle every output is 0.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ready: ir_we=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: single cycle, no enables. Classifies opcode.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011.
  - Any other opcode (including instr[1:0] != 2'b11) sets illegal=1 and goes to HALT.
  - 1110011 (ECALL/EBREAK) goes to HALT with illegal=0.
  - All other legal opcodes go to EXEC.
- EXEC, by opcode:
  - R-type: a=rs1, b=rs2, op=1; then WB.
  - OP-IMM: a=rs1, b=imm, op=1; then WB.
  - LUI: a=zero, b=imm, op=0; then WB.
  - AUIPC: a=PC, b=imm, op=0; then WB.
  - LOAD/STORE: a=rs1, b=imm, op=0; then MEM. The datapath registers the ALU result every cycle; the address is held stable through MEM.
  - BRANCH: a=PC, b=imm, op=0; pc_we=1; pc_src = br_taken ? 1 : 0. Retires; next state FETCH.
  - JAL: a=PC, b=imm, op=0; reg_we=1, wb_sel=2; pc_we=1, pc_src=1. Retires; FETCH.
  - JALR: a=rs1, b=imm, op=0; reg_we=1, wb_sel=2; pc_we=1, pc_src=2. Retires; FETCH.
  - FENCE: pc_we=1, pc_src=0; acts as NOP. Retires; FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE, 0 for LOAD.
  - On mem_ready, STORE: pc_we=1, pc_src=0, retires; FETCH.
  - On mem_ready, LOAD: go to WB. The datapath latches read data on mem_ready.
- WB: reg_we=1; wb_sel=1 for LOAD, else 0; pc_we=1, pc_src=0. Retires; FETCH.
- Retire: instret increments by 1 in every cycle with pc_we=1. 0xFFFFFFFF wraps to 0.
- Latency with zero-wait memory (mem_ready in the first cycle of FETCH/MEM):
  - BRANCH, JAL, JALR, FENCE: 3 cycles.
  - ALU, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to FETCH/MEM and on mem_ready; increments each FETCH/MEM cycle with mem_req=1 and mem_ready=0.
  - If MAX_WAIT != 0 and the counter reaches MAX_WAIT with mem_ready still 0: bus_err=1, go to HALT. mem_req drops next cycle.
  - mem_ready in the same cycle as the limit wins; no error.
- HALT: all enables 0, mem_req=0, halted=1. Exits only via rst.
- Handshake: while mem_req=1 and mem_ready=0, mem_we and mem_addr_sel stay stable. mem_ready while mem_req=0 is ignored.
- Reset mid-access: FSM abandons the request. mem_req=0 in the rst cycle; FETCH starts the following cycle. No write enable fires in the rst cycle.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093), zero-wait memory → FETCH/DECODE/EXEC/WB in 4 cycles; reg_we=1 with wb_sel=0 in cycle 4; pc_we with pc_src=0; instret=1.
- LW x2,0(x1) with mem_ready delayed 3 cycles in MEM → mem_req=1, mem_addr_sel=1, mem_we=0 held for 4 cycles; then WB with wb_sel=1; total 8 cycles.
- BEQ, br_taken=1 then a second BEQ with br_taken=0 → pc_src=1 then 0, each in 3 cycles; reg_we never asserted.
- JALR x1,8(x2) → single EXEC cycle with reg_we=1, wb_sel=2, pc_src=2, alu_a_sel=0, alu_b_sel=1.
- Opcode 0x0000007F, then ECALL (0x00000073) after a fresh reset → illegal=1, halted=1 after DECODE; then halted=1 with illegal=0; instret unchanged in both cases.
- MAX_WAIT=4, mem_ready never asserted in FETCH → bus_err=1 and HALT after 4 FETCH cycles. Repeat with rst asserted during FETCH wait → mem_req=0 in the rst cycle; FETCH restarts next cycle; all sticky flags cleared.
